// File: rtl/match_ctrl.sv
// match_ctrl: round/match sequencer for a versus fighting game.
//
// Tracks per-player health and round wins, walks through
// IDLE -> INTRO -> FIGHT -> KO -> (INTRO | MATCH_END), and reports the
// winner of each round and of the match. Frame-based durations advance
// only on cycles where frame_tick is high.
//
// Ports:
//   Clk           single system clock
//   Reset         asynchronous, active-high reset
//   frame_tick    one-Clk pulse per video frame
//   start         one-Clk pulse from the decoded start key
//   hit_valid     bit i requests damage to player i
//   hit_dmg       damage for player i in bits [8i+7:8i]
//   state         IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_END=4
//   health        per-player health, HW bits per player
//   wins          per-player round wins, WW bits per player
//   round_num     current round, 1-based, saturating at 15
//   timer         frame ticks remaining in the round
//   round_winner  winner of the last round, 7 = draw
//   match_winner  winner of the match, 7 = none
//
// Optional feature: define MATCH_CTRL_TIMEOUT_EN to enable the round
// timer. With it, the timer counts down on frame ticks during FIGHT and a
// round that reaches zero is awarded to the unique healthiest player
// (a tie is a draw). Without it, timer reads 0 and only a KO ends a round.

module match_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int HEALTH_MAX    = 100,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int INTRO_FRAMES  = 60,
  parameter int KO_FRAMES     = 120,
  parameter int ROUND_FRAMES  = 5400,
  localparam int HW = $clog2(HEALTH_MAX + 1),
  localparam int WW = $clog2(ROUNDS_TO_WIN + 1),
  localparam int TW = $clog2(ROUND_FRAMES + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic [NUM_PLAYERS-1:0]    hit_valid,
  input  logic [8*NUM_PLAYERS-1:0]  hit_dmg,
  output logic [2:0]                state,
  output logic [HW*NUM_PLAYERS-1:0] health,
  output logic [WW*NUM_PLAYERS-1:0] wins,
  output logic [3:0]                round_num,
  output logic [TW-1:0]             timer,
  output logic [2:0]                round_winner,
  output logic [2:0]                match_winner
);

  localparam int FRAMES_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int FCW        = $clog2(FRAMES_MAX + 1);

  localparam logic [2:0]    NO_PLAYER = 3'd7;
  localparam logic [HW-1:0] FULL_HP   = HW'(HEALTH_MAX);
  localparam logic [WW-1:0] WIN_CAP   = WW'(ROUNDS_TO_WIN);
  localparam logic [3:0]    ROUND_CAP = 4'd15;

`ifdef MATCH_CTRL_TIMEOUT_EN
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_FRAMES);
`else
  localparam logic [TW-1:0] TIMER_LOAD = '0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTRO     = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_KO        = 3'd3,
    ST_MATCH_END = 3'd4
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [HW-1:0]  health_q [NUM_PLAYERS];
  logic [HW-1:0]  health_d [NUM_PLAYERS];
  logic [WW-1:0]  wins_q   [NUM_PLAYERS];
  logic [WW-1:0]  wins_d   [NUM_PLAYERS];
  logic [3:0]     round_q, round_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     round_winner_q, round_winner_d;
  logic [2:0]     match_winner_q, match_winner_d;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [HW-1:0]  hit_health [NUM_PLAYERS]; // health after this cycle's hits
  logic [2:0]     alive_cnt;                // players with hit_health > 0
  logic [2:0]     alive_idx;                // highest-index surviving player
  logic           champ_found;              // some player holds ROUNDS_TO_WIN
  logic [2:0]     champ_idx;
  logic           award;                    // a round win is credited this edge
  logic [2:0]     award_idx;

`ifdef MATCH_CTRL_TIMEOUT_EN
  logic           timeout;
  logic [HW-1:0]  top_health;
  logic [2:0]     top_idx;
  logic           top_tie;
`endif

  // Saturating damage and survivor count. Hits are evaluated for every
  // player in parallel so simultaneous hits land on the same edge.
  always_comb begin
    hit_health = health_q;
    alive_cnt  = '0;
    alive_idx  = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (hit_valid[i]) begin
        if (32'(hit_dmg[8*i +: 8]) >= 32'(health_q[i])) begin
          hit_health[i] = '0;
        end else begin
          hit_health[i] = health_q[i] - HW'(hit_dmg[8*i +: 8]);
        end
      end
      if (hit_health[i] != '0) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = 3'(i);
      end
    end
  end

  // Match winner lookup; only one player can reach the cap since at most
  // one win is credited per round.
  always_comb begin
    champ_found = 1'b0;
    champ_idx   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (!champ_found && wins_q[i] == WIN_CAP) begin
        champ_found = 1'b1;
        champ_idx   = 3'(i);
      end
    end
  end

`ifdef MATCH_CTRL_TIMEOUT_EN
  // Healthiest player after this cycle's hits; a shared maximum is a tie.
  always_comb begin
    top_health = hit_health[0];
    top_idx    = '0;
    top_tie    = 1'b0;
    for (int unsigned i = 1; i < NUM_PLAYERS; i++) begin
      if (hit_health[i] > top_health) begin
        top_health = hit_health[i];
        top_idx    = 3'(i);
        top_tie    = 1'b0;
      end else if (hit_health[i] == top_health) begin
        top_tie = 1'b1;
      end
    end
  end

  // The tick that takes the timer from 1 to 0 ends the round.
  assign timeout = frame_tick && (timer_q <= TW'(1));
`endif

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    health_d       = health_q;
    wins_d         = wins_q;
    round_d        = round_q;
    timer_d        = timer_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    award          = 1'b0;
    award_idx      = '0;

    unique case (state_q)
      ST_IDLE, ST_MATCH_END: begin
        if (start) begin
          state_d        = ST_INTRO;
          frame_cnt_d    = '0;
          round_d        = 4'd1;
          timer_d        = TIMER_LOAD;
          match_winner_d = NO_PLAYER;
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            health_d[i] = FULL_HP;
            wins_d[i]   = '0;
          end
        end
      end

      ST_INTRO: begin
        if (frame_tick) begin
          if (frame_cnt_q == FCW'(INTRO_FRAMES - 1)) begin
            state_d     = ST_FIGHT;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_FIGHT: begin
        health_d = hit_health;
`ifdef MATCH_CTRL_TIMEOUT_EN
        if (frame_tick && timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end
`endif
        // A KO is checked first so it takes precedence over a timeout
        // landing on the same edge.
        if (alive_cnt <= 3'd1) begin
          state_d     = ST_KO;
          frame_cnt_d = '0;
          if (alive_cnt == 3'd1) begin
            round_winner_d = alive_idx;
            award          = 1'b1;
            award_idx      = alive_idx;
          end else begin
            round_winner_d = NO_PLAYER;
          end
        end
`ifdef MATCH_CTRL_TIMEOUT_EN
        else if (timeout) begin
          state_d     = ST_KO;
          frame_cnt_d = '0;
          if (!top_tie) begin
            round_winner_d = top_idx;
            award          = 1'b1;
            award_idx      = top_idx;
          end else begin
            round_winner_d = NO_PLAYER;
          end
        end
`endif
      end

      ST_KO: begin
        if (frame_tick) begin
          if (frame_cnt_q == FCW'(KO_FRAMES - 1)) begin
            frame_cnt_d = '0;
            if (champ_found) begin
              state_d        = ST_MATCH_END;
              match_winner_d = champ_idx;
            end else begin
              state_d = ST_INTRO;
              timer_d = TIMER_LOAD;
              if (round_q != ROUND_CAP) begin
                round_d = round_q + 1'b1;
              end
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                health_d[i] = FULL_HP;
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Credit the round win, saturating at ROUNDS_TO_WIN.
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (award && award_idx == 3'(i) && wins_q[i] != WIN_CAP) begin
        wins_d[i] = wins_q[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= '0;
      round_q        <= '0;
      timer_q        <= '0;
      round_winner_q <= NO_PLAYER;
      match_winner_q <= NO_PLAYER;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        health_q[i] <= FULL_HP;
        wins_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      round_q        <= round_d;
      timer_q        <= timer_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      health_q       <= health_d;
      wins_q         <= wins_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    health = '0;
    wins   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      health[i*HW +: HW] = health_q[i];
      wins[i*WW +: WW]   = wins_q[i];
    end
  end

  assign state        = state_q;
  assign round_num    = round_q;
  assign timer        = timer_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;

endmodule
